// File: rtl/pingpong_ioram_pkg.sv
// Shared types for the ping-pong I/O RAM: bank lifecycle states and bank count.
package pingpong_ioram_pkg;

    localparam int NUM_BANKS = 2;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    function automatic logic bank_writable(input bank_state_e s);
        return (s == BANK_EMPTY) || (s == BANK_FILLING);
    endfunction

    function automatic logic bank_readable(input bank_state_e s);
        return (s == BANK_FULL) || (s == BANK_DRAINING);
    endfunction

endpackage

// File: rtl/pingpong_ioram_bank.sv
// ppram_bank: simple dual-port synchronous RAM, one write port with per-lane
// enables and one registered read port that only updates when rd_en is high.
module ppram_bank
    import pingpong_ioram_pkg::*;
#(
    parameter int DW = 8,
    parameter int DN = 7,
    parameter int AW = 14
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DW*DN-1:0] wr_data,
    input  logic [DN-1:0]    wr_lane_en,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [DW*DN-1:0] rd_data
);

    logic [DW*DN-1:0] mem [0:(1<<AW)-1];
    logic [DW*DN-1:0] rd_data_q;

    // NOTE: the array and its read register have no reset, so they map onto
    // block RAM; contents after reset are whatever was last written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < DN; i++) begin
                if (wr_lane_en[i]) mem[wr_addr][i*DW +: DW] <= wr_data[i*DW +: DW];
            end
        end
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pingpong_ioram.sv
// Two-bank ping-pong RAM: the writer fills one bank while the reader drains the
// other. Define PINGPONG_IORAM_WMASK_EN to add the w_lane_en per-lane write mask.
module pingpong_ioram
    import pingpong_ioram_pkg::*;
#(
    parameter int DW = 8,
    parameter int DN = 7,
    parameter int AW = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    w_addr,
    input  logic             w_addr_first,
    input  logic             w_addr_last,
    input  logic             w_addr_valid,
    output logic             w_addr_ready,
    input  logic [DW*DN-1:0] w_data,
`ifdef PINGPONG_IORAM_WMASK_EN
    input  logic [DN-1:0]    w_lane_en,
`endif
    input  logic [AW-1:0]    r_addr,
    input  logic             r_addr_first,
    input  logic             r_addr_last,
    input  logic             r_addr_valid,
    output logic             r_addr_ready,
    output logic [DW*DN-1:0] r_data,
    output logic             r_data_first,
    output logic             r_data_last,
    output logic             r_data_valid,
    input  logic             r_data_ready,
    output logic [1:0]       bank_full,
    output logic             err
);

    bank_state_e state_q [NUM_BANKS];
    bank_state_e state_d [NUM_BANKS];
    logic wsel_q, wsel_d;
    logic rsel_q, rsel_d;
    logic rd_bank_q, rd_bank_d;
    logic r_data_valid_q, r_data_valid_d;
    logic r_data_first_q, r_data_first_d;
    logic r_data_last_q, r_data_last_d;
    logic err_q, err_d;

    logic w_hs, r_hs;
    logic [DN-1:0] lane_en;
    logic [DW*DN-1:0] bank_rdata [NUM_BANKS];

`ifdef PINGPONG_IORAM_WMASK_EN
    assign lane_en = w_lane_en;
`else
    assign lane_en = '1;
`endif

    assign w_addr_ready = bank_writable(state_q[wsel_q]);
    assign r_addr_ready = bank_readable(state_q[rsel_q]) && (!r_data_valid_q || r_data_ready);
    assign w_hs = w_addr_valid && w_addr_ready;
    assign r_hs = r_addr_valid && r_addr_ready;

    // Writer and reader can never own the same bank (writable vs readable
    // states are disjoint), so both updates below apply independently.
    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves it unassigned,
        // which keeps this block purely combinational (no latches).
        for (int b = 0; b < NUM_BANKS; b++) state_d[b] = state_q[b];
        wsel_d         = wsel_q;
        rsel_d         = rsel_q;
        rd_bank_d      = rd_bank_q;
        r_data_valid_d = r_data_valid_q;
        r_data_first_d = r_data_first_q;
        r_data_last_d  = r_data_last_q;
        err_d          = err_q;

        if (w_hs) begin
            case (state_q[wsel_q])
                BANK_EMPTY: begin
                    if (!w_addr_first) begin
                        err_d = 1'b1;
                    end else if (w_addr_last) begin
                        state_d[wsel_q] = BANK_FULL;
                        wsel_d          = ~wsel_q;
                    end else begin
                        state_d[wsel_q] = BANK_FILLING;
                    end
                end
                BANK_FILLING: begin
                    if (w_addr_first) err_d = 1'b1;
                    if (w_addr_last) begin
                        state_d[wsel_q] = BANK_FULL;
                        wsel_d          = ~wsel_q;
                    end
                end
                default: ;
            endcase
        end

        if (r_hs) begin
            r_data_valid_d = 1'b1;
            r_data_first_d = r_addr_first;
            r_data_last_d  = r_addr_last;
            rd_bank_d      = rsel_q;
            if (r_addr_last) begin
                state_d[rsel_q] = BANK_EMPTY;
                rsel_d          = ~rsel_q;
            end else begin
                state_d[rsel_q] = BANK_DRAINING;
            end
        end else if (r_data_ready) begin
            r_data_valid_d = 1'b0;
            r_data_first_d = 1'b0;
            r_data_last_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) state_q[b] <= BANK_EMPTY;
            wsel_q         <= 1'b0;
            rsel_q         <= 1'b0;
            rd_bank_q      <= 1'b0;
            r_data_valid_q <= 1'b0;
            r_data_first_q <= 1'b0;
            r_data_last_q  <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) state_q[b] <= state_d[b];
            wsel_q         <= wsel_d;
            rsel_q         <= rsel_d;
            rd_bank_q      <= rd_bank_d;
            r_data_valid_q <= r_data_valid_d;
            r_data_first_q <= r_data_first_d;
            r_data_last_q  <= r_data_last_d;
            err_q          <= err_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ppram_bank #(.DW(DW), .DN(DN), .AW(AW)) u_bank (
            .clk        (clk),
            .wr_en      (w_hs && (wsel_q == 1'(b))),
            .wr_addr    (w_addr),
            .wr_data    (w_data),
            .wr_lane_en (lane_en),
            .rd_en      (r_hs && (rsel_q == 1'(b))),
            .rd_addr    (r_addr),
            .rd_data    (bank_rdata[b])
        );
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) bank_full[b] = bank_readable(state_q[b]);
    end

    // The read register of the bank that served the last request holds steady
    // while the sink stalls, because its read port is not re-enabled.
    assign r_data       = bank_rdata[rd_bank_q];
    assign r_data_valid = r_data_valid_q;
    assign r_data_first = r_data_first_q;
    assign r_data_last  = r_data_last_q;
    assign err          = err_q;

endmodule

// File: tb/tb_pingpong_ioram.sv
// Randomized self-checking bench for pingpong_ioram against a burst-level
// reference model (memory map per bank plus writer/reader bank pointers).
module tb_pingpong_ioram;

    localparam int DW = 8;
    localparam int DN = 7;
    localparam int AW = 14;
    localparam int W  = DW * DN;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] w_addr = '0;
    logic          w_addr_first = 1'b0, w_addr_last = 1'b0, w_addr_valid = 1'b0;
    logic          w_addr_ready;
    logic [W-1:0]  w_data = '0;
    logic [DN-1:0] lane_en = '1;
    logic [AW-1:0] r_addr = '0;
    logic          r_addr_first = 1'b0, r_addr_last = 1'b0, r_addr_valid = 1'b0;
    logic          r_addr_ready;
    logic [W-1:0]  r_data;
    logic          r_data_first, r_data_last, r_data_valid;
    logic          r_data_ready = 1'b0;
    logic [1:0]    bank_full;
    logic          err;

    int total = 0;
    int bad   = 0;

    // Reference model: word per (bank, address), bank pointers, last burst per bank.
    logic [W-1:0]  mdl [int];
    int            wr_bank_m = 0;
    int            rd_bank_m = 0;
    logic [AW-1:0] baddr [2][64];
    int            blen [2];

    always #5 clk = ~clk;

    pingpong_ioram #(.DW(DW), .DN(DN), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_addr       (w_addr),
        .w_addr_first (w_addr_first),
        .w_addr_last  (w_addr_last),
        .w_addr_valid (w_addr_valid),
        .w_addr_ready (w_addr_ready),
        .w_data       (w_data),
`ifdef PINGPONG_IORAM_WMASK_EN
        .w_lane_en    (lane_en),
`endif
        .r_addr       (r_addr),
        .r_addr_first (r_addr_first),
        .r_addr_last  (r_addr_last),
        .r_addr_valid (r_addr_valid),
        .r_addr_ready (r_addr_ready),
        .r_data       (r_data),
        .r_data_first (r_data_first),
        .r_data_last  (r_data_last),
        .r_data_valid (r_data_valid),
        .r_data_ready (r_data_ready),
        .bank_full    (bank_full),
        .err          (err)
    );

    function automatic int key(input int b, input logic [AW-1:0] a);
        return b * (1 << AW) + int'(a);
    endfunction

    // All tasks start and end on a falling edge.
    task automatic wr_beat(input logic [AW-1:0] a, input logic [W-1:0] d, input logic f, input logic l);
        int budget = 200;
        logic [W-1:0] word;
        w_addr = a; w_data = d; w_addr_first = f; w_addr_last = l; w_addr_valid = 1'b1;
        #1;
        while (!w_addr_ready && budget > 0) begin
            @(negedge clk); #1; budget--;
        end
        total++;
        if (!w_addr_ready) begin
            bad++; $display("FAIL wr_accept addr=%0h ready=%b want 1 within budget", a, w_addr_ready);
        end
        @(negedge clk);
        w_addr_valid = 1'b0;
        word = mdl.exists(key(wr_bank_m, a)) ? mdl[key(wr_bank_m, a)] : 'x;
        for (int i = 0; i < DN; i++) if (lane_en[i]) word[i*DW +: DW] = d[i*DW +: DW];
        mdl[key(wr_bank_m, a)] = word;
        if (l) wr_bank_m ^= 1;
    endtask

    task automatic rd_beat(input logic [AW-1:0] a, input logic f, input logic l, input int stall);
        int budget = 200;
        logic [W-1:0] exp;
        exp = mdl[key(rd_bank_m, a)];
        r_addr = a; r_addr_first = f; r_addr_last = l; r_addr_valid = 1'b1; r_data_ready = 1'b1;
        #1;
        while (!r_addr_ready && budget > 0) begin
            @(negedge clk); #1; budget--;
        end
        total++;
        if (!r_addr_ready) begin
            bad++; $display("FAIL rd_accept addr=%0h ready=%b want 1 within budget", a, r_addr_ready);
        end
        @(negedge clk);
        r_addr_valid = 1'b0;
        if (l) rd_bank_m ^= 1;
        total++;
        if (r_data_valid !== 1'b1 || r_data !== exp || r_data_first !== f || r_data_last !== l) begin
            bad++;
            $display("FAIL rd_data addr=%0h got v=%b d=%h f=%b l=%b want v=1 d=%h f=%b l=%b",
                     a, r_data_valid, r_data, r_data_first, r_data_last, exp, f, l);
        end
        if (stall > 0) begin
            r_data_ready = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                total++;
                if (r_data_valid !== 1'b1 || r_data !== exp || r_addr_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL rd_stall got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                             r_data_valid, r_data, r_addr_ready, exp);
                end
            end
            r_data_ready = 1'b1;
        end
    endtask

    task automatic wr_burst(input int n, input bit seq);
        int b = wr_bank_m;
        blen[b] = n;
        for (int i = 0; i < n; i++) begin
            baddr[b][i] = seq ? AW'(i) : AW'($urandom);
            wr_beat(baddr[b][i], seq ? W'(i) : W'({$urandom, $urandom}), i == 0, i == n - 1);
        end
    endtask

    task automatic rd_burst(input int stall_at, input int stall_len);
        int b = rd_bank_m;
        for (int i = 0; i < blen[b]; i++)
            rd_beat(baddr[b][i], i == 0, i == blen[b] - 1, (i == stall_at) ? stall_len : 0);
        @(negedge clk);
        total++;
        if (r_data_valid !== 1'b0) begin
            bad++; $display("FAIL rd_tail r_data_valid=%b want 0 (duplicate beat)", r_data_valid);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_err);
        total++;
        if (w_addr_ready !== 1'b1 || r_addr_ready !== 1'b0 || bank_full !== 2'b00 || err !== exp_err ||
            r_data_valid !== 1'b0 || r_data_first !== 1'b0 || r_data_last !== 1'b0) begin
            bad++;
            $display("FAIL %s got wrdy=%b rrdy=%b full=%b err=%b v=%b f=%b l=%b want 1 0 00 %b 0 0 0",
                     tag, w_addr_ready, r_addr_ready, bank_full, err, r_data_valid, r_data_first,
                     r_data_last, exp_err);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        w_addr_valid = 1'b0; r_addr_valid = 1'b0; r_data_ready = 1'b0; lane_en = '1;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        wr_bank_m = 0; rd_bank_m = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("reset_asserted", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_released", 1'b0);
    endtask

    task automatic test_basic();
        wr_burst(16, 1'b1);
        total++;
        if (bank_full !== 2'b01 || w_addr_ready !== 1'b1) begin
            bad++; $display("FAIL basic_full got full=%b wrdy=%b want 01 1", bank_full, w_addr_ready);
        end
        rd_burst(-1, 0);
        total++;
        if (bank_full !== 2'b00) begin
            bad++; $display("FAIL basic_drained got full=%b want 00", bank_full);
        end
    endtask

    task automatic test_single();
        logic [1:0] exp_full;
        exp_full = 2'(1 << wr_bank_m);
        wr_beat(AW'(5), W'('hAB), 1'b1, 1'b1);
        total++;
        if (bank_full !== exp_full) begin
            bad++; $display("FAIL single_full got %b want %b", bank_full, exp_full);
        end
        rd_beat(AW'(5), 1'b1, 1'b1, 0);
        total++;
        if (r_data !== W'('hAB) || bank_full !== 2'b00) begin
            bad++; $display("FAIL single_read got d=%h full=%b want ab 00", r_data, bank_full);
        end
    endtask

    task automatic test_backpressure();
        int b;
        wr_burst(8, 1'b0);
        wr_burst(8, 1'b0);
        total++;
        if (bank_full !== 2'b11 || w_addr_ready !== 1'b0) begin
            bad++; $display("FAIL bp_both_full got full=%b wrdy=%b want 11 0", bank_full, w_addr_ready);
        end
        w_addr = AW'($urandom); w_data = W'({$urandom, $urandom});
        w_addr_first = 1'b1; w_addr_last = 1'b1; w_addr_valid = 1'b1;
        b = rd_bank_m;
        for (int i = 0; i < blen[b]; i++) begin
            total++;
            if (w_addr_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold beat=%0d wrdy=%b want 0", i, w_addr_ready);
            end
            rd_beat(baddr[b][i], i == 0, i == blen[b] - 1, 0);
        end
        total++;
        if (w_addr_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release wrdy=%b want 1", w_addr_ready);
        end
        w_addr_valid = 1'b0;
        rd_burst(-1, 0);
    endtask

    task automatic test_stall();
        wr_burst(8, 1'b0);
        rd_burst(3, 3);
    endtask

    task automatic test_concurrent();
        time t0;
        wr_burst(8, 1'b0);
        t0 = $time;
        fork
            wr_burst(8, 1'b0);
            rd_burst(-1, 0);
        join
        total++;
        if ($time - t0 > 90) begin
            bad++; $display("FAIL concurrent_rate took %0t want <= 90", $time - t0);
        end
        rd_burst(-1, 0);
    endtask

    task automatic test_random();
        int n;
        repeat (6) begin
            n = $urandom_range(1, 12);
            wr_burst(n, 1'b0);
            rd_burst($urandom_range(0, n - 1), $urandom_range(0, 3));
        end
    endtask

    task automatic test_err_empty();
        do_reset();
        wr_beat(AW'(1), W'(1), 1'b0, 1'b0);
        total++;
        if (err !== 1'b1) begin
            bad++; $display("FAIL err_no_first err=%b want 1", err);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_drain();
        wr_beat(AW'(10), W'({$urandom, $urandom}), 1'b1, 1'b0);
        wr_beat(AW'(11), W'({$urandom, $urandom}), 1'b1, 1'b0);
        wr_beat(AW'(12), W'({$urandom, $urandom}), 1'b0, 1'b1);
        total++;
        if (err !== 1'b1 || bank_full !== 2'b01) begin
            bad++; $display("FAIL err_refirst got err=%b full=%b want 1 01", err, bank_full);
        end
        rd_beat(AW'(10), 1'b1, 1'b0, 0);
        rd_beat(AW'(11), 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check_idle("reset_mid_drain", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_bank_m = 0; rd_bank_m = 0;
        @(negedge clk);
        check_idle("after_mid_reset", 1'b0);
        wr_burst(4, 1'b0);
        rd_burst(-1, 0);
    endtask

`ifdef PINGPONG_IORAM_WMASK_EN
    task automatic test_wmask();
        lane_en = '1;
        wr_beat(AW'(9), '1, 1'b1, 1'b0);
        lane_en = 7'b0000001;
        wr_beat(AW'(9), '0, 1'b0, 1'b1);
        lane_en = '1;
        rd_beat(AW'(9), 1'b1, 1'b1, 0);
        total++;
        if (r_data !== {{(W-DW){1'b1}}, {DW{1'b0}}}) begin
            bad++; $display("FAIL wmask got %h want lane0=00 others ff", r_data);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_backpressure();
        test_stall();
        test_concurrent();
        test_random();
        test_err_empty();
        test_reset_mid_drain();
`ifdef PINGPONG_IORAM_WMASK_EN
        test_wmask();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
